wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_stage_load_align.sv | 51 +++++
 rtl/wb_stage.sv | 125 ++++++++++++
 tb/tb_wb_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-stage constants: source indices and RV load funct3 encodings.
package wb_pkg;

  localparam int unsigned WB_SEL_DMEM = 0;
  localparam int unsigned WB_SEL_ALU  = 1;
  localparam int unsigned WB_SEL_PC4  = 2;
  localparam int unsigned WB_SEL_CSR  = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: extracts byte/half/word from DMEM read data
// and sign- or zero-extends it; flags misaligned half/word accesses.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] dmem_data,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misalign
);

  logic [31:0] shifted_s;

  assign shifted_s = dmem_data[31:0] >> {addr_lo, 3'b000};

  // Select and extend the addressed lane.
  always_comb begin
    load_data = '0;
    misalign  = 1'b0;
    case (funct3)
      F3_LB:  load_data = {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]};
      F3_LH: begin
        if (addr_lo[0]) begin
          misalign = 1'b1;
        end else begin
          load_data = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      F3_LHU: begin
        if (addr_lo[0]) begin
          misalign = 1'b1;
        end else begin
          load_data = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
        end
      end
      F3_LW: begin
        if (addr_lo != 2'b00) begin
          misalign = 1'b1;
        end else begin
          load_data = dmem_data;
        end
      end
      default: load_data = dmem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline register: selects and formats the result, then presents
// a one-cycle-delayed register-file write port with sticky error flags.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_SRC       = 4,
  parameter int SEL_WIDTH     = $clog2(NUM_SRC),
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_src,
  input  logic [SEL_WIDTH-1:0]          in_sel,
  input  logic [RF_ADDR_WIDTH-1:0]      in_rd,
  input  logic                          in_we,
  input  logic [2:0]                    in_funct3,
  input  logic [1:0]                    in_addr_lo,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          wb_we,
  output logic [RF_ADDR_WIDTH-1:0]      wb_rd,
  output logic [DATA_WIDTH-1:0]         wb_data,
  output logic                          wb_valid,
  output logic                          err_sel,
  output logic                          err_misalign
);

  localparam logic [SEL_WIDTH:0] NUM_SRC_L = (SEL_WIDTH+1)'(NUM_SRC);

  logic [DATA_WIDTH-1:0]    src_s;
  logic [DATA_WIDTH-1:0]    load_data_s;
  logic                     misalign_s;
  logic                     sel_legal_s;
  logic                     is_dmem_s;
  logic [DATA_WIDTH-1:0]    next_data_s;
  logic                     bad_sel_s;
  logic                     bad_mis_s;
  logic                     capture_we_s;

  logic                     valid_r;
  logic                     we_r;
  logic [RF_ADDR_WIDTH-1:0] rd_r;
  logic [DATA_WIDTH-1:0]    data_r;
  logic                     err_sel_r;
  logic                     err_mis_r;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .dmem_data (in_src[DATA_WIDTH-1:0]),
    .funct3    (in_funct3),
    .addr_lo   (in_addr_lo),
    .load_data (load_data_s),
    .misalign  (misalign_s)
  );

  assign sel_legal_s = ({1'b0, in_sel} < NUM_SRC_L);
  assign is_dmem_s   = (in_sel == SEL_WIDTH'(WB_SEL_DMEM));

  // Raw source mux; out-of-range selects fall through to zero.
  always_comb begin
    src_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_WIDTH'(k)) begin
        src_s = in_src[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        src_s = src_s;
      end
    end
  end

  // Final data and error classification; faulting instructions write zero.
  always_comb begin
    next_data_s = '0;
    bad_sel_s   = 1'b0;
    bad_mis_s   = 1'b0;
    if (!sel_legal_s) begin
      bad_sel_s = 1'b1;
    end else if (is_dmem_s) begin
      if (misalign_s) begin
        bad_mis_s = 1'b1;
      end else begin
        next_data_s = load_data_s;
      end
    end else begin
      next_data_s = src_s;
    end
  end

  // x0 and faulting instructions never produce a write enable.
  assign capture_we_s = in_valid & in_we & ~bad_sel_s & ~bad_mis_s &
                        (in_rd != {RF_ADDR_WIDTH{1'b0}});

  // WB register: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= 1'b0;
      we_r      <= 1'b0;
      rd_r      <= '0;
      data_r    <= '0;
      err_sel_r <= 1'b0;
      err_mis_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
    end else if (!stall) begin
      valid_r   <= in_valid;
      we_r      <= capture_we_s;
      rd_r      <= in_rd;
      data_r    <= next_data_s;
      err_sel_r <= err_sel_r | (in_valid & bad_sel_s);
      err_mis_r <= err_mis_r | (in_valid & bad_mis_s);
    end else begin
      valid_r <= valid_r;
    end
  end

  assign wb_we        = we_r;
  assign wb_rd        = rd_r;
  assign wb_data      = data_r;
  assign wb_valid     = valid_r;
  assign err_sel      = err_sel_r;
  assign err_misalign = err_mis_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (default config plus a NUM_SRC=3 copy).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_we, stall, flush;
  logic [127:0] in_src;
  logic [1:0]  in_sel;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        wb_we, wb_valid, err_sel, err_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        b_valid, b_we;
  logic [95:0] b_src;
  logic [1:0]  b_sel;
  logic [4:0]  b_rd;
  logic        b_wb_we, b_wb_valid, b_err_sel, b_err_misalign;
  logic [4:0]  b_wb_rd;
  logic [31:0] b_wb_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_src(in_src), .in_sel(in_sel),
    .in_rd(in_rd), .in_we(in_we), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_valid(wb_valid), .err_sel(err_sel), .err_misalign(err_misalign)
  );

  wb_stage #(.NUM_SRC(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_src(b_src), .in_sel(b_sel),
    .in_rd(b_rd), .in_we(b_we), .in_funct3(3'b010), .in_addr_lo(2'b00),
    .stall(1'b0), .flush(1'b0), .wb_we(b_wb_we), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .wb_valid(b_wb_valid), .err_sel(b_err_sel), .err_misalign(b_err_misalign)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] s0,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] s3,
                       input logic [4:0] rd, input logic we, input logic [2:0] f3,
                       input logic [1:0] alo);
    in_valid   = v;
    in_sel     = sel;
    in_src     = {s3, s2, s1, s0};
    in_rd      = rd;
    in_we      = we;
    in_funct3  = f3;
    in_addr_lo = alo;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 2'd1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd9, 1'b1, 3'b010, 2'b00);
    b_valid = 1'b0; b_we = 1'b0; b_sel = 2'd0; b_rd = 5'd0; b_src = 96'h0;
    tick; tick;
    total++;
    if ({wb_we, wb_valid, wb_rd, wb_data, err_sel, err_misalign} !== 40'h0) begin
      bad++;
      $display("FAIL reset got we=%b v=%b rd=%0d data=%h es=%b em=%b exp all 0",
               wb_we, wb_valid, wb_rd, wb_data, err_sel, err_misalign);
    end
    total++;
    if ({b_wb_we, b_wb_valid, b_wb_rd, b_wb_data, b_err_sel} !== 39'h0) begin
      bad++;
      $display("FAIL reset3 got we=%b v=%b data=%h es=%b exp all 0",
               b_wb_we, b_wb_valid, b_wb_data, b_err_sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu;
    drive(1'b1, 2'd1, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 5'd7, 1'b1, 3'b000, 2'b11);
    tick;
    total++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h1234_5678 || wb_valid !== 1'b1) begin
      bad++;
      $display("FAIL alu got we=%b rd=%0d data=%h v=%b exp we=1 rd=7 data=12345678 v=1",
               wb_we, wb_rd, wb_data, wb_valid);
    end
  endtask

  task automatic test_load;
    logic [2:0]  f3 [6]  = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010, 3'b100};
    logic [1:0]  alo [6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3};
    logic [31:0] exp [6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF,
                             32'hFFFF_80FF, 32'h80FF_7F01, 32'h0000_0080};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd0, 32'h80FF_7F01, 32'h1111_1111, 32'h0, 32'h0, 5'd4, 1'b1, f3[i], alo[i]);
      tick;
      total++;
      if (wb_data !== exp[i] || wb_we !== 1'b1) begin
        bad++;
        $display("FAIL load%0d got data=%h we=%b exp data=%h we=1", i, wb_data, wb_we, exp[i]);
      end
    end
  endtask

  task automatic test_passthrough;
    drive(1'b1, 2'd2, 32'h80FF_7F01, 32'h0, 32'hFFFF_FF84, 32'h0, 5'd1, 1'b1, 3'b000, 2'b11);
    tick;
    total++;
    if (wb_data !== 32'hFFFF_FF84 || err_misalign !== 1'b0) begin
      bad++;
      $display("FAIL pc4 got data=%h em=%b exp data=ffffff84 em=0", wb_data, err_misalign);
    end
    drive(1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'hC5C5_0301, 5'd2, 1'b1, 3'b010, 2'b01);
    tick;
    total++;
    if (wb_data !== 32'hC5C5_0301 || wb_rd !== 5'd2 || err_misalign !== 1'b0) begin
      bad++;
      $display("FAIL csr got data=%h rd=%0d em=%b exp data=c5c50301 rd=2 em=0",
               wb_data, wb_rd, err_misalign);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 32'h0, d[i], 32'h0, 32'h0, 5'(i + 10), 1'b1, 3'b000, 2'b00);
      tick;
      total++;
      if (wb_data !== d[i] || wb_rd !== 5'(i + 10) || wb_we !== 1'b1) begin
        bad++;
        $display("FAIL b2b%0d got data=%h rd=%0d we=%b exp data=%h rd=%0d we=1",
                 i, wb_data, wb_rd, wb_we, d[i], i + 10);
      end
    end
    drive(1'b0, 2'd1, 32'h0, 32'h5555_5555, 32'h0, 32'h0, 5'd6, 1'b1, 3'b000, 2'b00);
    tick;
    total++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      bad++;
      $display("FAIL bubble got v=%b we=%b exp v=0 we=0", wb_valid, wb_we);
    end
  endtask

  task automatic test_stall_flush;
    drive(1'b1, 2'd1, 32'h0, 32'hAAAA_0001, 32'h0, 32'h0, 5'd5, 1'b1, 3'b000, 2'b00);
    tick;
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      drive(1'b1, 2'd2, 32'h0, 32'h0, 32'(32'h7000_0000 + i), 32'h0, 5'(i + 20), 1'b1, 3'b000, 2'b00);
      tick;
      total++;
      if (wb_data !== 32'hAAAA_0001 || wb_rd !== 5'd5 || wb_we !== 1'b1 || wb_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall%0d got data=%h rd=%0d we=%b v=%b exp data=aaaa0001 rd=5 we=1 v=1",
                 i, wb_data, wb_rd, wb_we, wb_valid);
      end
    end
    flush = 1'b1;
    tick;
    total++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      bad++;
      $display("FAIL stall_flush got v=%b we=%b exp v=0 we=0", wb_valid, wb_we);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_x0;
    drive(1'b1, 2'd1, 32'h0, 32'h0BAD_0000, 32'h0, 32'h0, 5'd0, 1'b1, 3'b000, 2'b00);
    tick;
    total++;
    if (wb_we !== 1'b0 || wb_valid !== 1'b1) begin
      bad++;
      $display("FAIL x0 got we=%b v=%b exp we=0 v=1", wb_we, wb_valid);
    end
  endtask

  task automatic test_misalign;
    drive(1'b1, 2'd0, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 3'b010, 2'b10);
    tick;
    total++;
    if (wb_we !== 1'b0 || wb_data !== 32'h0 || err_misalign !== 1'b1 || err_sel !== 1'b0) begin
      bad++;
      $display("FAIL misalign got we=%b data=%h em=%b es=%b exp we=0 data=0 em=1 es=0",
               wb_we, wb_data, err_misalign, err_sel);
    end
    drive(1'b1, 2'd1, 32'h0, 32'h0000_0042, 32'h0, 32'h0, 5'd8, 1'b1, 3'b000, 2'b00);
    tick; tick;
    total++;
    if (err_misalign !== 1'b1 || wb_we !== 1'b1 || wb_data !== 32'h42) begin
      bad++;
      $display("FAIL misalign_sticky got em=%b we=%b data=%h exp em=1 we=1 data=42",
               err_misalign, wb_we, wb_data);
    end
  endtask

  task automatic test_bad_sel;
    b_valid = 1'b0; b_we = 1'b1; b_sel = 2'd3; b_rd = 5'd4;
    b_src = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tick;
    total++;
    if (b_err_sel !== 1'b0) begin
      bad++;
      $display("FAIL badsel_novalid got es=%b exp es=0", b_err_sel);
    end
    b_valid = 1'b1;
    tick;
    total++;
    if (b_err_sel !== 1'b1 || b_wb_we !== 1'b0 || b_wb_data !== 32'h0) begin
      bad++;
      $display("FAIL badsel got es=%b we=%b data=%h exp es=1 we=0 data=0",
               b_err_sel, b_wb_we, b_wb_data);
    end
    b_sel = 2'd2;
    tick;
    total++;
    if (b_err_sel !== 1'b1 || b_wb_we !== 1'b1 || b_wb_data !== 32'h3333_3333) begin
      bad++;
      $display("FAIL badsel_sticky got es=%b we=%b data=%h exp es=1 we=1 data=33333333",
               b_err_sel, b_wb_we, b_wb_data);
    end
  endtask

  task automatic test_rst_mid;
    drive(1'b1, 2'd1, 32'h0, 32'h7777_0007, 32'h0, 32'h0, 5'd15, 1'b1, 3'b000, 2'b00);
    tick;
    rst = 1'b1; flush = 1'b0; stall = 1'b1;
    tick;
    total++;
    if ({wb_we, wb_valid, wb_rd, wb_data, err_sel, err_misalign} !== 40'h0) begin
      bad++;
      $display("FAIL rst_mid got we=%b v=%b rd=%0d data=%h es=%b em=%b exp all 0",
               wb_we, wb_valid, wb_rd, wb_data, err_sel, err_misalign);
    end
    total++;
    if ({b_wb_we, b_wb_valid, b_wb_data, b_err_sel} !== 35'h0) begin
      bad++;
      $display("FAIL rst_mid3 got we=%b v=%b data=%h es=%b exp all 0",
               b_wb_we, b_wb_valid, b_wb_data, b_err_sel);
    end
    rst = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_passthrough;
    test_back_to_back;
    test_stall_flush;
    test_x0;
    test_misalign;
    test_bad_sel;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
